// File: rtl/sr_cmd_debounce.sv
// Two-channel push-button debouncer that turns each qualified press into a one-cycle S or R pulse.
// Define SR_CMD_SYNC_EN to add a two-flop synchronizer on both raw inputs.
module sr_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       reset_btn,
  output logic       S,
  output logic       R,
  output logic       conflict,
  output logic [1:0] dbg_set_state,
  output logic [1:0] dbg_reset_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK_P = 2'd1,
    ST_PRESSED = 2'd2,
    ST_CHECK_R = 2'd3
  } state_t;

  // A run qualifies on the sample that brings the count to DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] samp;

`ifdef SR_CMD_SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {reset_btn, set_btn};
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = {reset_btn, set_btn};
`endif

  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       ev;

  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ev[i]      = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (samp[i]) begin
            state_d[i] = ST_CHECK_P;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_CHECK_P: begin
          if (!samp[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
            ev[i]      = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!samp[i]) begin
            state_d[i] = ST_CHECK_R;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_CHECK_R: begin
          if (samp[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end

    // Reset wins a same-edge collision; the set channel still latches PRESSED.
    s_d        = ev[0] & ~ev[1];
    r_d        = ev[1];
    conflict_d = ev[0] & ev[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  // Pulses are plain registered strobes with no backpressure: the consumer must take them the cycle they appear.
  assign S               = s_q;
  assign R               = r_q;
  assign conflict        = conflict_q;
  assign dbg_set_state   = state_q[0];
  assign dbg_reset_state = state_q[1];

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Self-checking bench for sr_cmd_debounce: directed test-plan steps plus random bouncy stimulus,
// checked against a sample-history debounce model.
module tb_sr_cmd_debounce;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_btn = 1'b0;
  logic       reset_btn = 1'b0;
  logic       S, R, conflict;
  logic [1:0] dbg_set_state, dbg_reset_state;

  int tests_run = 0;
  int fails     = 0;
  int s_cnt = 0, r_cnt = 0, c_cnt = 0;

  // Model state: debounced level and the trailing sample history per channel.
  bit         lvl [2];
  bit         hist0 [$];
  bit         hist1 [$];
  bit         p1 [2];
  bit         p2 [2];
  logic [2:0] exp_q [$];

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .set_btn         (set_btn),
    .reset_btn       (reset_btn),
    .S               (S),
    .R               (R),
    .conflict        (conflict),
    .dbg_set_state   (dbg_set_state),
    .dbg_reset_state (dbg_reset_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit all_are(input bit q [$], input bit v);
    if (q.size() != DB) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  // Level flips once the last DB samples all disagree with it; a 0->1 flip is a press event.
  task automatic model_edge(input bit r_in, input bit s_raw, input bit r_raw);
    bit samp [2];
    bit ev [2];
    if (r_in) begin
      hist0.delete();
      hist1.delete();
      lvl = '{0, 0};
      p1  = '{0, 0};
      p2  = '{0, 0};
      exp_q.push_back(3'b000);
      return;
    end
`ifdef SR_CMD_SYNC_EN
    samp = p2;
    p2   = p1;
    p1   = '{s_raw, r_raw};
`else
    samp = '{s_raw, r_raw};
`endif
    ev = '{0, 0};
    hist0.push_back(samp[0]);
    if (hist0.size() > DB) void'(hist0.pop_front());
    hist1.push_back(samp[1]);
    if (hist1.size() > DB) void'(hist1.pop_front());
    if (all_are(hist0, !lvl[0])) begin
      lvl[0] = !lvl[0];
      ev[0]  = lvl[0];
    end
    if (all_are(hist1, !lvl[1])) begin
      lvl[1] = !lvl[1];
      ev[1]  = lvl[1];
    end
    exp_q.push_back({ev[0] & ev[1], ev[1], ev[0] & !ev[1]});
  endtask

  task automatic step(input bit r_in, input bit s_in, input bit rb_in);
    logic [2:0] e;
    @(negedge clk);
    rst       = r_in;
    set_btn   = s_in;
    reset_btn = rb_in;
    @(posedge clk);
    #1;
    model_edge(r_in, s_in, rb_in);
    e = exp_q.pop_front();
    check("S", S, e[0]);
    check("R", R, e[1]);
    check("conflict", conflict, e[2]);
    check("S_and_R", S & R, 0);
    s_cnt += S;
    r_cnt += R;
    c_cnt += conflict;
  endtask

  task automatic hold(input int n, input bit s_in, input bit rb_in);
    for (int i = 0; i < n; i++) step(1'b0, s_in, rb_in);
  endtask

  task automatic clear_counts();
    s_cnt = 0;
    r_cnt = 0;
    c_cnt = 0;
  endtask

  initial begin
    bit bounce_pat [7];
    bit s_lvl, r_lvl;
    bounce_pat = '{1, 1, 0, 1, 1, 0, 1};
    lvl = '{0, 0};
    p1  = '{0, 0};
    p2  = '{0, 0};

    // Reset held with set pressed, then release: one pulse after DB fresh samples.
    clear_counts();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_state_set", dbg_set_state, 0);
    check("rst_state_reset", dbg_reset_state, 0);
    check("rst_no_pulse", s_cnt + r_cnt + c_cnt, 0);
    hold(8, 1'b1, 1'b0);
    check("post_rst_s_pulses", s_cnt, 1);
    hold(8, 1'b0, 1'b0);

    // Clean press held 20 cycles.
    clear_counts();
    hold(20, 1'b1, 1'b0);
    check("clean_s_pulses", s_cnt, 1);
    check("clean_r_pulses", r_cnt, 0);
    hold(8, 1'b0, 1'b0);

    // Bounce rejection, then a solid 4-sample hold.
    clear_counts();
    foreach (bounce_pat[i]) step(1'b0, bounce_pat[i], 1'b0);
    check("bounce_no_pulse", s_cnt, 0);
    hold(4, 1'b1, 1'b0);
    check("bounce_then_hold", s_cnt, 1);

    // Release debounce: short drops do not re-arm the press.
    clear_counts();
    hold(2, 1'b0, 1'b0);
    hold(3, 1'b1, 1'b0);
    hold(4, 1'b0, 1'b0);
    check("release_no_extra", s_cnt, 0);
    hold(4, 1'b0, 1'b0);
    hold(6, 1'b1, 1'b0);
    check("fresh_press", s_cnt, 1);
    hold(8, 1'b0, 1'b0);

    // Collision: reset wins, dropped set is not replayed while held.
    clear_counts();
    hold(8, 1'b1, 1'b1);
    check("coll_r", r_cnt, 1);
    check("coll_conflict", c_cnt, 1);
    check("coll_s", s_cnt, 0);
    hold(12, 1'b1, 1'b0);
    check("coll_no_replay", s_cnt, 0);
    hold(8, 1'b0, 1'b0);
    hold(6, 1'b1, 1'b0);
    check("coll_repress", s_cnt, 1);
    hold(8, 1'b0, 1'b0);

    // Reset mid-qualification discards progress; held button re-qualifies.
    clear_counts();
    hold(2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(3, 1'b1, 1'b0);
    check("midrst_not_yet", s_cnt, 0);
    hold(4, 1'b1, 1'b0);
    check("midrst_requal", s_cnt, 1);
    hold(8, 1'b0, 1'b0);

    // Random bouncy levels with occasional reset.
    s_lvl = 1'b0;
    r_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) s_lvl = !s_lvl;
      if ($urandom_range(0, 7) == 0) r_lvl = !r_lvl;
      step($urandom_range(0, 79) == 0, s_lvl, r_lvl);
    end
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sr_cmd_debounce.md
# sr_cmd_debounce

Upstream command stage for the SR flip-flop. It takes two raw, bouncy push-button levels (set and reset) and turns each qualified press into a single-cycle `S` or `R` pulse. The two outputs are never high together, and any press collision is arbitrated deterministically. `S`/`R` connect directly to the SR flip-flop inputs on the same `clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples needed to qualify a press or a release; legal range 2..255.
- `CNT_W`, default 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `set_btn`  input  1  raw set button level, asynchronous to `clk`, may bounce.
- `reset_btn`  input  1  raw reset button level, asynchronous to `clk`, may bounce.
- `S`  output  1  one-cycle set command pulse to the SR flip-flop.
- `R`  output  1  one-cycle reset command pulse to the SR flip-flop.
- `conflict`  output  1  one-cycle pulse when an `S` event was dropped by arbitration.

## Operation
- Two identical channels (set, reset). Each channel has its own FSM and its own `CNT_W` counter.
- Channel states:
  - IDLE: input is low. Sample high → CHECK_P, cnt=1.
  - CHECK_P: sample low → IDLE, cnt=0. Sample high with cnt+1 == DEBOUNCE_CYCLES → PRESSED and raise the channel event. Otherwise cnt++.
  - PRESSED: sample low → CHECK_R, cnt=1. Sample high → stay.
  - CHECK_R: sample high → PRESSED, cnt=0, no new event. Sample low with cnt+1 == DEBOUNCE_CYCLES → IDLE, cnt=0. Otherwise cnt++.
- Events fire only on the CHECK_P→PRESSED transition. Holding a button produces exactly one pulse; a second pulse requires a qualified release first.
- Arbitration:
  - Only the set event fires: `S`=1.
  - Only the reset event fires: `R`=1.
  - Both fire on the same edge: `R`=1, `S`=0, `conflict`=1. The set channel still moves to PRESSED, so the dropped press is not replayed.
- Invariant: `S` & `R` == 0 on every cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Timing
- Reset, with `rst`=1 sampled at an edge:
  - both FSMs → IDLE, counters → 0;
  - `S`=0, `R`=0, `conflict`=0 from that edge on.
  - Reset has priority over every other event.
- Reset mid-operation: any in-progress check or pending pulse is discarded. A button still held after `rst` deasserts re-qualifies from IDLE and pulses after DEBOUNCE_CYCLES samples.
- Latency without the synchronizer:
  - first high sample at edge k;
  - `S`/`R` high for exactly one period starting at edge k+DEBOUNCE_CYCLES-1;
  - low again at edge k+DEBOUNCE_CYCLES.
- Latency with `SR_CMD_SYNC_EN`: add 2 cycles to every figure above.
- `S`, `R` and `conflict` are driven directly from flops, with no combinational path from the inputs.
- Minimum pulse spacing on one channel: 2×DEBOUNCE_CYCLES cycles (press qualification plus release qualification).

## Configuration
- `SR_CMD_SYNC_EN` defined:
  - `set_btn` and `reset_btn` each pass through a two-flop synchronizer before the FSMs;
  - synchronizer flops reset to 0;
  - latency +2 cycles.
- `SR_CMD_SYNC_EN` undefined:
  - raw inputs feed the FSMs directly;
  - the source must already be synchronous to `clk`.

## Test plan
All cases use DEBOUNCE_CYCLES=4, 10 ns clock, `SR_CMD_SYNC_EN` undefined unless stated.
- Reset: `rst`=1 for 2 cycles with `set_btn`=1 → `S`=`R`=`conflict`=0 throughout. After release, `S` pulses once, 4 cycles later.
- Clean set press: `set_btn` high at edge k, held 20 cycles → `S`=1 exactly at k+3..k+4, `R`=0 always, no second pulse while held.
- Bounce rejection: `set_btn` pattern 1,1,0,1,1,0,1 (per cycle) → no `S` pulse. Then hold 1 for 4 samples → single `S` pulse.
- Release debounce: after a qualified press, drop for 2 cycles, raise for 3, drop for 4 → no extra pulse. A fresh press then yields one more `S`.
- Collision: both buttons rise on the same edge and are held → `R`=1, `conflict`=1 for one cycle, `S`=0. No later `S` until `set_btn` is released and re-pressed.
- With `SR_CMD_SYNC_EN` defined, repeat the clean set press → pulse at k+5..k+6.
